// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits++;
            rem = rem >> 1;
        end
        if (bits < 1) bits = 1;
        return bits;
    endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_fa_cell.sv
// Combinational full adder made of two half-adder stages and an OR on their carries.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    assign ha0_s = a ^ b;
    assign ha0_c = a & b;
    assign s     = ha0_s ^ ci;
    assign ha1_c = ha0_s & ci;
    assign co    = ha0_c | ha1_c;

endmodule : serial_fa_cell

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with start/busy/done handshake and held result.
// Optional signed-overflow output OVF is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int             CW       = clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-2:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_s;
    logic fa_co;

    serial_fa_cell u_fa (
        .a  (sh_a_q[0]),
        .b  (sh_b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    sh_a_d  = A;
                    sh_b_d  = B;
                    carry_d = CIN;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                carry_d = fa_co;
                sh_a_d  = sh_a_q >> 1;
                sh_b_d  = sh_b_q >> 1;
                // Accumulator keeps the WIDTH-1 earlier bits; the newest bit enters at the top.
                acc_d   = (WIDTH-1)'({fa_s, acc_q} >> 1);
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_s, acc_q};
                    cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ fa_co;
`endif
                    cnt_d   = '0;
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            // NOTE: the datapath registers are cleared too, so an aborted add leaves no stale bits behind.
            state_q <= ST_IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign BUSY = (state_q == ST_ADD);
    assign DONE = (state_q == ST_FIN);
    assign SUM  = sum_q;
    assign COUT = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign OVF  = ovf_q;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8; OVF is checked when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
`ifdef SERIAL_ADDER_OVF_EN
    logic             OVF;
`endif

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .A     (A),
        .B     (B),
        .CIN   (CIN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SUM   (SUM),
        .COUT  (COUT)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .OVF   (OVF)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One full transaction; operands are scrambled right after the accept edge.
    task automatic apply(input vec_t v);
        int n;
        int busy_bad;
        @(negedge CLK);
        A = v.a; B = v.b; CIN = v.cin; START = 1'b1;
        tick();
        START = 1'b0;
        A = ~v.a; B = v.b ^ 8'h5A; CIN = ~v.cin;
        check("busy_after_accept", 32'(BUSY), 32'd1);
        n = 0;
        busy_bad = 0;
        do begin
            tick();
            n++;
            if (!DONE && !BUSY) busy_bad++;
        end while (!DONE && n < WIDTH + 4);
        check("done_latency", 32'(n), 32'(WIDTH));
        check("busy_stays_high", 32'(busy_bad), 32'd0);
        check("busy_low_at_done", 32'(BUSY), 32'd0);
        check("sum", 32'(SUM), 32'(v.sum));
        check("cout", 32'(COUT), 32'(v.cout));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 32'(OVF), 32'(v.ovf));
`endif
        tick();
        check("done_one_cycle", 32'(DONE), 32'd0);
        check("sum_held", 32'(SUM), 32'(v.sum));
    endtask

    initial begin
        vec_t vecs[12];
        int   dones;
        int   done_edge;
        logic [7:0] sum_at_done;
        logic [8:0] exp9;
        logic [7:0] ra, rb;
        logic       rc;
        int   n;

        vecs[0]  = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[6]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[7]  = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0};
        vecs[8]  = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[9]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[10] = '{8'h01, 8'h7E, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[11] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

        RST_N = 1'b0; START = 1'b0; A = '0; B = '0; CIN = 1'b0;
        repeat (2) tick();
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_sum", 32'(SUM), 32'd0);
        check("rst_cout", 32'(COUT), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", 32'(OVF), 32'd0);
`endif
        RST_N = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) apply(vecs[i]);

        // START re-asserted mid-add must be ignored.
        @(negedge CLK);
        A = 8'h10; B = 8'h20; CIN = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        dones = 0; done_edge = 0; sum_at_done = '0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (DONE) begin
                dones++;
                done_edge = e;
                sum_at_done = SUM;
            end
            if (e == 2) begin
                START = 1'b1; A = 8'h01; B = 8'h01;
            end
            if (e == 3) START = 1'b0;
        end
        check("ignore_start_dones", 32'(dones), 32'd1);
        check("ignore_start_edge", 32'(done_edge), 32'(WIDTH));
        check("ignore_start_sum", 32'(sum_at_done), 32'h30);

        // Reset at edge 4 of an add aborts it with no DONE.
        @(negedge CLK);
        A = 8'hAA; B = 8'h11; CIN = 1'b1; START = 1'b1;
        tick();
        START = 1'b0;
        dones = 0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (DONE) dones++;
            if (e == 3) RST_N = 1'b0;
            if (e == 4) begin
                check("abort_busy", 32'(BUSY), 32'd0);
                check("abort_sum", 32'(SUM), 32'd0);
                check("abort_cout", 32'(COUT), 32'd0);
                RST_N = 1'b1;
            end
        end
        check("abort_no_done", 32'(dones), 32'd0);
        apply('{8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0});

        // Reset and START on the same edge: reset wins.
        @(negedge CLK);
        RST_N = 1'b0; START = 1'b1; A = 8'h05; B = 8'h05;
        tick();
        check("rst_wins_busy", 32'(BUSY), 32'd0);
        RST_N = 1'b1; START = 1'b0;
        tick();
        check("rst_wins_idle", 32'(BUSY), 32'd0);

        // Soak with START held high: one accept every WIDTH+2 cycles.
        @(negedge CLK);
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
        A = ra; B = rb; CIN = rc; START = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!DONE && n < 3 * WIDTH);
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            check("soak_spacing", 32'(n), (i == 0) ? 32'(WIDTH + 1) : 32'(WIDTH + 2));
            check("soak_sum", 32'(SUM), 32'(exp9[7:0]));
            check("soak_cout", 32'(COUT), 32'(exp9[8]));
`ifdef SERIAL_ADDER_OVF_EN
            check("soak_ovf", 32'(OVF), 32'((ra[7] == rb[7]) && (exp9[7] != ra[7])));
`endif
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            A = ra; B = rb; CIN = rc;
        end
        START = 1'b0;
        repeat (WIDTH + 3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_adder
